l2_arbiter: RTL and testbench
=============================

# l2_arbiter

- Two-port arbiter that shares the single unified L2 cache port between the L1 instruction cache and the L1 data cache.
- Sits between both L1 miss paths and the L2 cache controller.
- Latches the winning request, drives the L2 handshake, routes the response back to the winner and inserts one idle turnaround cycle between transactions.
- Keeps saturating per-requester service counters for performance monitoring.

## Interface
Parameters:
- ADDR_W, 16, address width (lc3b word address space)
- LINE_W, 128, cache line width in bits
- CNT_W, 16, service counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_read  in  1  I-cache line read request (level, held until i_resp)
- i_addr  in  ADDR_W  I-cache request address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  I-cache transaction complete
- d_read  in  1  D-cache line read request (level)
- d_write  in  1  D-cache line write-back request (level)
- d_addr  in  ADDR_W  D-cache request address
- d_wdata  in  LINE_W  D-cache write-back line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  D-cache transaction complete
- l2_read  out  1  read request to L2 controller
- l2_write  out  1  write request to L2 controller
- l2_addr  out  ADDR_W  latched address to L2
- l2_wdata  out  LINE_W  latched write line to L2
- l2_rdata  in  LINE_W  line from L2
- l2_resp  in  1  L2 transaction complete
- i_count  out  CNT_W  completed I-cache transactions, saturating
- d_count  out  CNT_W  completed D-cache transactions, saturating

## Operation
States:
- IDLE: arbitrate.
- I_BUSY: I-cache transaction owns the L2 port.
- D_BUSY: D-cache transaction owns the L2 port.
- GAP: one-cycle turnaround.

IDLE:
- Only i_read high → latch i_addr, go to I_BUSY.
- Only d_read or d_write high → latch d_addr and d_wdata, latch op (write if d_write, else read), go to D_BUSY.
- Both requesters high → grant the requester not recorded in last_grant; update last_grant to the winner.
- last_grant resets to D, so the I-cache wins the first tie.
- d_read and d_write both high is illegal; d_write wins and d_read is ignored.

I_BUSY:
- l2_read=1, l2_write=0, l2_addr=latched address.
- On l2_resp: i_resp=1 in the same cycle, i_count increments, go to GAP.

D_BUSY:
- l2_read = latched op is read; l2_write = latched op is write; l2_addr and l2_wdata from latches.
- On l2_resp: d_resp=1 in the same cycle, d_count increments, go to GAP.

GAP:
- All l2 request outputs are 0; go to IDLE unconditionally.
- Lets the L2 controller return to its hold state and the L1 requester drop or renew its request.

Data return and gating:
- i_rdata and d_rdata both carry l2_rdata combinationally; only the resp strobe qualifies the data.
- i_resp and d_resp are 0 in all states except their own BUSY state with l2_resp=1.
- l2_resp arriving in IDLE or GAP is ignored.

Latches and counters:
- Requester inputs that change during BUSY are ignored; the latched address, data and op are used.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
Reset (asynchronous, rst high):
- state=IDLE, last_grant=D, latches=0, counters=0.
- All outputs 0: l2_read, l2_write, l2_addr, l2_wdata, i_resp, d_resp, i_count, d_count.
- i_rdata and d_rdata follow l2_rdata.
- rst during BUSY abandons the L2 transaction with no resp to the requester; the L2 controller is reset with the same rst.

Cycle-level sequence:
- Request sampled in IDLE at edge 0.
- l2_read or l2_write asserted from cycle 1.
- Requester resp is in the same cycle as l2_resp (latency = L2 latency + 1 cycle).
- GAP follows, then IDLE.
- Back-to-back minimum: 3 cycles per transaction when the L2 hits in its first BUSY cycle.

L2 handshake:
- l2_read/l2_write are held stable until l2_resp.
- At most one of l2_read and l2_write is high in any cycle.

## Test plan
- Single I read: i_read=1, i_addr=16'h1230; L2 returns 128'hA5..A5 with l2_resp 4 cycles later → l2_read=1, l2_addr=16'h1230 from cycle 1; i_resp=1 with i_rdata=128'hA5..A5; d_resp stays 0; i_count=1.
- D write-back: d_write=1, d_addr=16'h8000, d_wdata=128'h0123..CDEF → l2_write=1 with latched data; d_resp pulses for one cycle; GAP shows l2_write=0.
- Tie from reset: i_read and d_read both rise in the same cycle.
  - I is served first; D is served on the next IDLE.
  - Service order over 4 continuous ties is I,D,I,D.
- Request change mid-transaction: change d_addr to 16'hFFFF while in D_BUSY → l2_addr holds the original address until l2_resp.
- Illegal and spurious inputs:
  - d_read=1 and d_write=1 together → only l2_write is asserted.
  - l2_resp pulsed in IDLE → no resp output, no state change.
- Reset mid-operation and saturation:
  - rst asserted during I_BUSY → all outputs 0 immediately; next tie is won by I.
  - Counter forced to 16'hFFFF, then one more completion → counter stays 16'hFFFF.

Source files
------------

// File: rtl/l2_arbiter.sv
// l2_arbiter: shares the unified L2 port between the L1 I-cache and D-cache
// with alternating tie-break, latched requests, a turnaround cycle and service counters.
module l2_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [CNT_W-1:0]  i_count,
  output logic [CNT_W-1:0]  d_count
);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, GAP} state_t;
  state_t              r_state, w_next;
  logic                r_last_d, r_op_w;
  logic [ADDR_W-1:0]   r_addr;
  logic [LINE_W-1:0]   r_wdata;
  logic [CNT_W-1:0]    r_i_count, r_d_count;
  logic                w_d_req, w_tie, w_grant_i, w_grant_d, w_idle;
  assign w_d_req   = d_read | d_write;
  assign w_tie     = i_read & w_d_req;
  assign w_idle    = r_state == IDLE;
  // On a tie the requester that did not win the previous tie gets the port.
  assign w_grant_i = w_idle & i_read & (~w_d_req | r_last_d);
  assign w_grant_d = w_idle & w_d_req & (~i_read | ~r_last_d);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_grant_i ? I_BUSY : w_grant_d ? D_BUSY : IDLE;
      I_BUSY:  w_next = l2_resp ? GAP : I_BUSY;
      D_BUSY:  w_next = l2_resp ? GAP : D_BUSY;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b1;
      r_op_w    <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_count <= '0;
      r_d_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant_i) r_addr <= i_addr;
      if (w_grant_d) begin
        r_addr  <= d_addr;
        r_wdata <= d_wdata;
        r_op_w  <= d_write;
      end
      if (w_idle && w_tie) r_last_d <= w_grant_d;
      if (i_resp && r_i_count != '1) r_i_count <= r_i_count + CNT_W'(1);
      if (d_resp && r_d_count != '1) r_d_count <= r_d_count + CNT_W'(1);
    end
  end
  assign i_resp   = (r_state == I_BUSY) & l2_resp;
  assign d_resp   = (r_state == D_BUSY) & l2_resp;
  assign l2_read  = (r_state == I_BUSY) | ((r_state == D_BUSY) & ~r_op_w);
  assign l2_write = (r_state == D_BUSY) & r_op_w;
  assign l2_addr  = (r_state == I_BUSY || r_state == D_BUSY) ? r_addr : '0;
  assign l2_wdata = (r_state == D_BUSY) ? r_wdata : '0;
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;
  assign i_count  = r_i_count;
  assign d_count  = r_d_count;
endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed test-plan scenarios plus random traffic, checked every
// cycle against a transaction-level model of the arbitration rules.
module tb_l2_arbiter;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;
  logic         clk = 1'b0, rst = 1'b0;
  logic         i_read = 0, d_read = 0, d_write = 0, l2_resp = 0;
  logic [15:0]  i_addr = 0, d_addr = 0;
  logic [127:0] d_wdata = 0, l2_rdata = 0;
  logic [127:0] i_rdata, d_rdata, l2_wdata;
  logic         i_resp, d_resp, l2_read, l2_write;
  logic [15:0]  l2_addr;
  logic [CW-1:0] i_count, d_count;
  int checks = 0, failures = 0;
  // model: phase 0 idle, 1 I owns port, 2 D owns port, 3 turnaround
  int           m_ph = 0;
  bit           m_last_d = 1, m_opw = 0;
  logic [15:0]  m_addr = 0;
  logic [127:0] m_wdata = 0;
  int           m_ic = 0, m_dc = 0;

  l2_arbiter #(.ADDR_W(16), .LINE_W(128), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp), .i_count(i_count), .d_count(d_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_last_d = 1; m_opw = 0; m_addr = 0; m_wdata = 0; m_ic = 0; m_dc = 0;
  endtask

  task automatic model_check();
    bit busy;
    if (rst) model_reset();
    busy = (m_ph == 1) || (m_ph == 2);
    chk("l2_read",  l2_read,  (m_ph == 1) || (m_ph == 2 && !m_opw));
    chk("l2_write", l2_write, m_ph == 2 && m_opw);
    chk("l2_addr",  l2_addr,  busy ? m_addr : 16'h0);
    chk("l2_wdata", l2_wdata, m_ph == 2 ? m_wdata : 128'h0);
    chk("i_resp",   i_resp,   m_ph == 1 && l2_resp);
    chk("d_resp",   d_resp,   m_ph == 2 && l2_resp);
    chk("i_rdata",  i_rdata,  l2_rdata);
    chk("d_rdata",  d_rdata,  l2_rdata);
    chk("i_count",  i_count,  m_ic);
    chk("d_count",  d_count,  m_dc);
  endtask

  task automatic model_advance();
    bit dreq, win_d;
    if (rst) return;
    dreq = d_read || d_write;
    case (m_ph)
      0: if (i_read || dreq) begin
        if (i_read && dreq) begin
          win_d = !m_last_d;
          m_last_d = win_d;
        end else win_d = dreq;
        m_ph = win_d ? 2 : 1;
        if (win_d) begin m_addr = d_addr; m_wdata = d_wdata; m_opw = d_write; end
        else m_addr = i_addr;
      end
      1: if (l2_resp) begin m_ph = 3; if (m_ic < MAX) m_ic++; end
      2: if (l2_resp) begin m_ph = 3; if (m_dc < MAX) m_dc++; end
      default: m_ph = 0;
    endcase
  endtask

  // called at a falling edge with inputs already set; returns at the next falling edge
  task automatic step();
    #2 model_check();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  task automatic quiet();
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
  endtask

  initial begin
    #1 rst = 1;
    @(negedge clk);
    #1 chk("rst_l2_read", l2_read, 0);
    chk("rst_i_count", i_count, 0);
    step();
    rst = 0;
    step();
    // single I read, L2 answers in the 4th busy cycle
    i_read = 1; i_addr = 16'h1230; step();
    for (int k = 0; k < 3; k++) begin
      #1 chk("ird_l2_read", l2_read, 1);
      chk("ird_l2_addr", l2_addr, 16'h1230);
      step();
    end
    l2_resp = 1; l2_rdata = {16{8'hA5}};
    #1 chk("ird_i_resp", i_resp, 1);
    chk("ird_i_rdata", i_rdata, {16{8'hA5}});
    chk("ird_d_resp", d_resp, 0);
    step();
    quiet(); #1 chk("ird_i_count", i_count, 1);
    step(); step();
    // D write-back
    d_write = 1; d_addr = 16'h8000; d_wdata = 128'h0123456789ABCDEF0123456789ABCDEF; step();
    d_write = 0; d_wdata = 0;
    #1 chk("dwb_l2_write", l2_write, 1);
    chk("dwb_l2_wdata", l2_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    l2_resp = 1; #1 chk("dwb_d_resp", d_resp, 1);
    step();
    l2_resp = 0; #1 chk("dwb_gap_write", l2_write, 0);
    chk("dwb_gap_resp", d_resp, 0);
    step();
    // ties from reset: order must be I,D,I,D
    rst = 1; step(); rst = 0;
    i_read = 1; d_read = 1; i_addr = 16'h0101; d_addr = 16'h0202;
    for (int k = 0; k < 4; k++) begin
      l2_resp = 0; step();
      l2_resp = 1; #1 chk("tie_order", {i_resp, d_resp}, (k % 2) ? 2'b01 : 2'b10);
      step();
      l2_resp = 0; step();
    end
    quiet();
    // D address changes mid-transaction
    d_read = 1; d_addr = 16'h1111; step();
    d_addr = 16'hFFFF;
    for (int k = 0; k < 2; k++) begin
      #1 chk("hold_l2_addr", l2_addr, 16'h1111);
      step();
    end
    l2_resp = 1; step(); quiet(); step();
    // d_read and d_write together: write wins
    d_read = 1; d_write = 1; d_addr = 16'h4444; step();
    quiet();
    #1 chk("ill_l2_write", l2_write, 1);
    chk("ill_l2_read", l2_read, 0);
    l2_resp = 1; step(); quiet(); step();
    // spurious l2_resp while idle
    l2_resp = 1; #1 chk("spur_resp", {i_resp, d_resp}, 2'b00);
    step();
    l2_resp = 0; #1 chk("spur_idle", {l2_read, l2_write}, 2'b00);
    step();
    // reset during I busy, then the next tie goes to I
    i_read = 1; i_addr = 16'h2222; step();
    rst = 1; #1 chk("rst_busy_read", l2_read, 0);
    chk("rst_busy_addr", l2_addr, 0);
    step();
    rst = 0; d_read = 1; i_addr = 16'h3333; d_addr = 16'h5555; step();
    #1 chk("rst_tie_i", l2_addr, 16'h3333);
    l2_resp = 1; step(); quiet(); step();
    // saturation of the I counter
    for (int k = 0; k < MAX + 2; k++) begin
      i_read = 1; step();
      l2_resp = 1; step();
      quiet(); step();
    end
    #1 chk("sat_i_count", i_count, MAX);
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(99) == 0);
      i_read   = $urandom_range(1);
      d_read   = $urandom_range(1);
      d_write  = ($urandom_range(3) == 0);
      i_addr   = 16'($urandom);
      d_addr   = 16'($urandom);
      d_wdata  = {$urandom, $urandom, $urandom, $urandom};
      l2_rdata = {$urandom, $urandom, $urandom, $urandom};
      l2_resp  = ($urandom_range(2) == 0);
      #1 chk("excl_rw", l2_read & l2_write, 0);
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
